// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
// Game sequencer for a two-player pong: owns the movement-tick prescaler,
// both scores and the IDLE/SERVE/PLAY/PAUSE/POINT/GAME_OVER flow, and gates
// the pad requests and the movement tick so nothing moves outside PLAY.
//
// Ports
//   clk                      single clock, all logic on posedge
//   rst                      synchronous active-high reset
//   start_btn, pause_btn     level buttons, rising edge acts
//   miss_left, miss_right    one-cycle pulses from the ball logic
//   up/down_l/r_in           raw pad requests
//   up/down_l/r              gated pad requests (raw AND in PLAY)
//   timing_tick              one-cycle movement tick, PLAY only
//   still_graphic            high forces pads and ball to the centre
//   score_left, score_right  current scores, saturating at 15
//   game_state               state register (encoding in table below)
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE   (0)  | power-up, waiting for start
// SERVE  (1)  | ball held at centre for SERVE_TICKS ticks
// PLAY   (2)  | ball and pads moving, misses score
// PAUSE  (3)  | frozen mid-rally, pause edge resumes
// POINT  (4)  | after a miss, held for POINT_TICKS ticks
// GAME_OVER(5)| a player reached WIN_SCORE, start restarts
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter int TICK_DIV    = 650000,
    parameter int SERVE_TICKS = 100,
    parameter int POINT_TICKS = 50,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       up_l_in,
    input  logic       down_l_in,
    input  logic       up_r_in,
    input  logic       down_r_in,
    output logic       up_l,
    output logic       down_l,
    output logic       up_r,
    output logic       down_r,
    output logic       timing_tick,
    output logic       still_graphic,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [2:0] game_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_POINT     = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]     SERVE_LAST = 16'(SERVE_TICKS - 1);
    localparam logic [15:0]     POINT_LAST = 16'(POINT_TICKS - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_presc;
    logic [15:0]    r_phase;
    logic [15:0]    w_phase_nxt;
    logic [3:0]     r_score_l;
    logic [3:0]     r_score_r;
    logic [3:0]     w_score_l_nxt;
    logic [3:0]     w_score_r_nxt;
    logic           r_start_q;
    logic           r_pause_q;
    logic           w_tick;
    logic           w_start_edge;
    logic           w_pause_edge;
    logic           w_play;
    logic           w_win;

    assign w_tick       = (r_presc == PRESC_LAST);
    assign w_start_edge = start_btn & ~r_start_q;
    assign w_pause_edge = pause_btn & ~r_pause_q;
    assign w_play       = (r_state == S_PLAY);
    assign w_win        = (int'(r_score_l) >= WIN_SCORE) || (int'(r_score_r) >= WIN_SCORE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_phase   <= '0;
            r_score_l <= '0;
            r_score_r <= '0;
            r_start_q <= 1'b0;
            r_pause_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_tick ? '0 : r_presc + 1'b1;
            r_phase   <= w_phase_nxt;
            r_score_l <= w_score_l_nxt;
            r_score_r <= w_score_r_nxt;
            r_start_q <= start_btn;
            r_pause_q <= pause_btn;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_score_l_nxt = r_score_l;
        w_score_r_nxt = r_score_r;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) w_state_nxt = S_SERVE;
            end
            S_SERVE: begin
                // r_phase holds ticks already seen, so the SERVE_TICKS-th tick
                // arrives while it reads SERVE_TICKS-1
                if (w_tick && (r_phase == SERVE_LAST)) w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                // a miss outranks a simultaneous pause edge; a double miss
                // is a dead ball and scores nobody
                if (miss_left || miss_right) begin
                    w_state_nxt = S_POINT;
                    if (miss_right && !miss_left && (r_score_l != 4'hF))
                        w_score_l_nxt = r_score_l + 4'd1;
                    if (miss_left && !miss_right && (r_score_r != 4'hF))
                        w_score_r_nxt = r_score_r + 4'd1;
                end else if (w_pause_edge) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_pause_edge) w_state_nxt = S_PLAY;
            end
            S_POINT: begin
                if (w_tick && (r_phase == POINT_LAST))
                    w_state_nxt = w_win ? S_GAME_OVER : S_SERVE;
            end
            S_GAME_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt   = S_SERVE;
                    w_score_l_nxt = 4'd0;
                    w_score_r_nxt = 4'd0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt != r_state)
            w_phase_nxt = 16'd0;
        else if (w_tick && ((r_state == S_SERVE) || (r_state == S_POINT)))
            w_phase_nxt = r_phase + 16'd1;
        else
            w_phase_nxt = r_phase;
    end

    assign timing_tick   = w_tick & w_play;
    assign still_graphic = ~(w_play | (r_state == S_PAUSE));
    assign up_l          = up_l_in   & w_play;
    assign down_l        = down_l_in & w_play;
    assign up_r          = up_r_in   & w_play;
    assign down_r        = down_r_in & w_play;
    assign score_left    = r_score_l;
    assign score_right   = r_score_r;
    assign game_state    = r_state;

endmodule
